// File: rtl/left_barrel_shifter_pipe_32bit.sv
// left_barrel_shifter_pipe_32bit: 5-stage pipelined 32-bit left shifter, valid/ready both sides.
// Define LBS_ROTATE_EN to add a rotate input that turns each stage into a rotate-left.
module left_barrel_shifter_pipe_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] In,
  input  logic [4:0]  load,
`ifdef LBS_ROTATE_EN
  input  logic        rotate,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

`ifdef LBS_ROTATE_EN
  typedef struct packed {
    logic        v;
    logic        rot;
    logic [4:0]  ld;
    logic [31:0] d;
  } stg_t;
`else
  typedef struct packed {
    logic        v;
    logic [4:0]  ld;
    logic [31:0] d;
  } stg_t;
`endif

  // one radix-2 step: shift (or rotate) by n when en is set
  function automatic stg_t step(
    input stg_t s,
    input logic en,
    input int   n
  );
    stg_t r;
    r = s;
    if (en) begin
`ifdef LBS_ROTATE_EN
      r.d = s.rot ? ((s.d << n) | (s.d >> (32 - n)))
                  : (s.d << n);
`else
      r.d = s.d << n;
`endif
    end
    return r;
  endfunction

  stg_t src;
  stg_t s1, s2, s3, s4, s5;
  logic r1, r2, r3, r4, r5;

  always_comb begin
    src    = '0;
    src.v  = in_valid;
    src.ld = load;
    src.d  = In;
`ifdef LBS_ROTATE_EN
    src.rot = rotate;
`endif
  end

  assign r5 = !s5.v || out_ready;
  assign r4 = !s4.v || r5;
  assign r3 = !s3.v || r4;
  assign r2 = !s2.v || r3;
  assign r1 = !s1.v || r2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
      s5 <= '0;
    end else begin
      if (r1) s1 <= step(src, src.ld[4], 16);
      if (r2) s2 <= step(s1, s1.ld[3], 8);
      if (r3) s3 <= step(s2, s2.ld[2], 4);
      if (r4) s4 <= step(s3, s3.ld[1], 2);
      if (r5) s5 <= step(s4, s4.ld[0], 1);
    end
  end

  assign in_ready  = r1;
  assign out       = s5.d;
  assign out_valid = s5.v;
  assign busy      = s1.v | s2.v | s3.v | s4.v | s5.v;

endmodule
